data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the multi-cycle MIPS core. It sits on the far side of the control unit's memory strobes (`mRD`/`mWR`) and datapath address/store buses. It services one word load or store per request after a fixed, parameterised wait, and returns a one-cycle `ready` pulse, plus `err` for illegal accesses. It owns the byte-wide big-endian data RAM, so the control unit's MEM state can be stretched to model a slow memory.

## Interface
- `DEPTH_BYTES`, 128: RAM size in bytes; must be a multiple of 4.
- `LATENCY`, 2: wait cycles between acceptance and completion; 0–15 legal.
- `clk` input, 1: single clock; everything on posedge.
- `rst` input, 1: reset; asynchronous, active-high.
- `mRD` input, 1: load request strobe (level), from the control unit.
- `mWR` input, 1: store request strobe (level), from the control unit.
- `addr` input, 32: byte address (ALU result).
- `wdata` input, 32: store data (register-file data2).
- `rdata` output, 32: load result; holds until the next successful load.
- `ready` output, 1: one-cycle completion pulse.
- `err` output, 1: qualifies `ready`; the access was illegal and was not performed.
- `busy` output, 1: high in every state except IDLE.

## Operation
- **States**: IDLE, WAIT, RESP, HOLD.
- **IDLE**:
  - `mRD ^ mWR` at a posedge accepts a request. `op`, `addr` and `wdata` are latched.
  - Next state is WAIT if `LATENCY>0`, else RESP.
  - `mRD & mWR` both high is accepted as an illegal request, with `err` forced.
- **WAIT**:
  - The counter loads `LATENCY-1` on acceptance and decrements each cycle.
  - At 0 it goes to RESP.
  - Inputs are ignored; only the latched values are used.
- **Commit on the edge entering RESP**:
  - Store: `mem[a]=wdata[31:24]`, `mem[a+1]=[23:16]`, `mem[a+2]=[15:8]`, `mem[a+3]=[7:0]`.
  - Load: `rdata` = the same big-endian byte concatenation.
- **Illegal access**: `addr[1:0]!=0`, `addr>DEPTH_BYTES-4`, or both strobes high.
  - No RAM write and no `rdata` update.
  - `err=1` during RESP.
- **RESP**: `ready=1` for exactly one cycle, then the state goes to HOLD.
- **HOLD**:
  - Waits until `mRD==0 && mWR==0` at a posedge, then returns to IDLE.
  - This prevents the control unit's level strobes (held for the whole MEM state) from causing a double store or a re-load.
  - The earliest new acceptance is the cycle after IDLE is re-entered.
- **Reset values**: `rdata=0`, `ready=0`, `err=0`, `busy=0`, state IDLE, counter 0. RAM contents are not cleared.
- **Reset mid-operation**:
  - Asserting `rst` in WAIT aborts the access. A store that has not reached the RESP edge leaves the RAM unchanged.
  - Asserting `rst` in RESP or HOLD discards the pending pulse or handshake.

## Timing
- The request is sampled at edge T0.
- `ready` is high during cycle T0+`LATENCY`+1 (registered output, no combinational path from the strobes).
- Load data is valid on `rdata` in the same cycle as `ready` and stays stable afterwards.
- `busy` rises the cycle after T0 and falls the cycle after the strobes are seen low in HOLD.
- `err` is registered and asserted only together with `ready`.
- Minimum request-to-request spacing is `LATENCY`+3 cycles (RESP, HOLD with strobes already low, IDLE).
- The address compare uses the full 32 bits, so there is no wrap-around. An address of `0xFFFFFFFC` is out of range.
- `LATENCY=0`: transition is IDLE→RESP directly; `ready` is high at T0+1.

## Test plan
- **Store then load, `LATENCY=2`**:
  - Stimulus: `mWR` held with `addr=0x10`, `wdata=0x12345678`; release after `ready`; then `mRD` with `addr=0x10`.
  - Required: `ready` pulses at T0+3 with `err=0`; `mem[0x10..0x13]=12,34,56,78`; `rdata=0x12345678` in the load's `ready` cycle.
- **Level strobe held 6 cycles**:
  - Stimulus: `mWR` held for 6 cycles with `wdata` changing each cycle.
  - Required: exactly one `ready`; RAM holds the value latched at T0; `busy` stays high until the strobe drops.
- **Illegal accesses**:
  - Stimulus: misaligned `addr=0x12` with `mRD`; also `addr=0x7D` (`DEPTH_BYTES=128`); also `mRD & mWR` both high.
  - Required: `ready` and `err` both 1; `rdata` unchanged; RAM unchanged.
- **Reset mid-store**:
  - Stimulus: `mWR` to `0x20`, `rst` pulsed in the first WAIT cycle.
  - Required: all outputs go to 0 immediately (async); a subsequent load of `0x20` returns the prior contents.
- **`LATENCY=0`, back-to-back**:
  - Stimulus: three loads with strobes dropped on each `ready`.
  - Required: `ready` at T0+1 for each load; requests spaced 3 cycles apart; correct data for each.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the multi-cycle MIPS core: one word load/store per
// strobe after a fixed wait, one-cycle ready/err pulse, byte-wide big-endian RAM.
module data_mem_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic        both_q, both_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [7:0]  mem_q [DEPTH_BYTES];

  logic        commit;
  logic        mem_we;
  logic        cur_store;
  logic        cur_both;
  logic        cur_ill;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] a0, a1, a2, a3;

  // In IDLE the live inputs are the request (needed for LATENCY=0 commits);
  // afterwards only the latched copies are used.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_store = mWR;
      cur_both  = mRD & mWR;
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_store = store_q;
      cur_both  = both_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_ill = cur_both || (cur_addr[1:0] != 2'b00) || (cur_addr > MAX_ADDR);
    a0 = {cur_addr[AW-1:2], 2'b00};
    a1 = {cur_addr[AW-1:2], 2'b01};
    a2 = {cur_addr[AW-1:2], 2'b10};
    a3 = {cur_addr[AW-1:2], 2'b11};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    both_d  = both_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mRD || mWR) begin
          store_d = mWR;
          both_d  = mRD & mWR;
          addr_d  = addr;
          wdata_d = wdata;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: begin
        if (!mRD && !mWR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      ready_d = 1'b1;
      err_d   = cur_ill;
      if (!cur_ill && !cur_store) rdata_d = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
    end

    mem_we = commit && !cur_ill && cur_store;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      both_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      both_q  <= both_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM is never cleared; a store in flight during reset must not land.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[a0] <= cur_wdata[31:24];
      mem_q[a1] <= cur_wdata[23:16];
      mem_q[a2] <= cur_wdata[15:8];
      mem_q[a3] <= cur_wdata[7:0];
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance (a) and LATENCY=0 instance (b).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mRD_a, mWR_a, mRD_b, mWR_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, err_a, busy_a, ready_b, err_b, busy_b;
  logic        sel;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_BYTES(128), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .mRD(mRD_a), .mWR(mWR_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  data_mem_responder #(.DEPTH_BYTES(128), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .mRD(mRD_b), .mWR(mWR_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  wire        ready_s = sel ? ready_b : ready_a;
  wire        err_s   = sel ? err_b   : err_a;
  wire        busy_s  = sel ? busy_b  : busy_a;
  wire [31:0] rdata_s = sel ? rdata_b : rdata_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (s) begin
      mRD_b = rd; mWR_b = wr; addr_b = a; wdata_b = d;
    end else begin
      mRD_a = rd; mWR_a = wr; addr_a = a; wdata_a = d;
    end
  endtask

  // Called at a negedge with the DUT idle; returns index of the accepting posedge.
  task automatic access(input bit s, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rdata,
                        input string tag, output int t0);
    int n;
    sel = s;
    t0  = cyc + 1;
    drive(s, rd, wr, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_s && n < 20);
    chk({tag, " latency"}, n, s ? 32'd1 : 32'd3);
    chk({tag, " err"}, {31'd0, err_s}, {31'd0, exp_err});
    chk({tag, " rdata"}, rdata_s, exp_rdata);
    chk({tag, " busy_resp"}, {31'd0, busy_s}, 32'd1);
    drive(s, 1'b0, 1'b0, a, d);
    @(negedge clk);
    chk({tag, " ready_pulse"}, {31'd0, ready_s}, 32'd0);
    chk({tag, " busy_hold"}, {31'd0, busy_s}, 32'd1);
    @(negedge clk);
    chk({tag, " busy_idle"}, {31'd0, busy_s}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, t3, nready;
    sel = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("reset rdata_a", rdata_a, 32'd0);
    chk("reset ready_a", {31'd0, ready_a}, 32'd0);
    chk("reset err_a",   {31'd0, err_a},   32'd0);
    chk("reset busy_a",  {31'd0, busy_a},  32'd0);
    chk("reset rdata_b", rdata_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Store then load, LATENCY=2
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'h0,        "st10", t);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678, "ld10", t);

    // Level strobe held for six edges with changing store data
    sel = 1'b0;
    nready = 0;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h0BADCAFE);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (ready_a) nready++;
      chk("lvl busy_held", {31'd0, busy_a}, 32'd1);
      wdata_a = 32'h11111111 * i;
    end
    @(negedge clk);
    if (ready_a) nready++;
    chk("lvl busy_hold", {31'd0, busy_a}, 32'd1);
    mWR_a = 1'b0;
    @(negedge clk);
    if (ready_a) nready++;
    chk("lvl busy_drop", {31'd0, busy_a}, 32'd0);
    chk("lvl ready_count", nready, 32'd1);
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0BADCAFE, "ld40", t);

    // Highest legal word
    access(1'b0, 1'b0, 1'b1, 32'h7C, 32'h7C7D7E7F, 1'b0, 32'h0BADCAFE, "st7c", t);
    access(1'b0, 1'b1, 1'b0, 32'h7C, 32'h0,        1'b0, 32'h7C7D7E7F, "ld7c", t);

    // Illegal accesses leave rdata and RAM untouched
    access(1'b0, 1'b1, 1'b0, 32'h12,       32'h0,        1'b1, 32'h7C7D7E7F, "ill_mis", t);
    access(1'b0, 1'b1, 1'b0, 32'h7D,       32'h0,        1'b1, 32'h7C7D7E7F, "ill_7d", t);
    access(1'b0, 1'b1, 1'b0, 32'h80,       32'h0,        1'b1, 32'h7C7D7E7F, "ill_80", t);
    access(1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h7C7D7E7F, "ill_fffc", t);
    access(1'b0, 1'b1, 1'b1, 32'h10,       32'hFFFFFFFF, 1'b1, 32'h7C7D7E7F, "ill_both", t);
    access(1'b0, 1'b0, 1'b1, 32'h7E,       32'hFFFFFFFF, 1'b1, 32'h7C7D7E7F, "ill_st7e", t);
    access(1'b0, 1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'h12345678, "ld10_again", t);
    access(1'b0, 1'b1, 1'b0, 32'h7C,       32'h0,        1'b0, 32'h7C7D7E7F, "ld7c_again", t);

    // Reset during WAIT aborts the store
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'h7C7D7E7F, "st20", t);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'hCAFEF00D, "ld20", t);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    chk("rst busy_wait", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    mWR_a = 1'b0;
    #1;
    chk("rst async rdata", rdata_a, 32'd0);
    chk("rst async ready", {31'd0, ready_a}, 32'd0);
    chk("rst async err",   {31'd0, err_a},   32'd0);
    chk("rst async busy",  {31'd0, busy_a},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, "ld20_after_rst", t);

    // LATENCY=0 instance: preload, then three back-to-back loads
    access(1'b1, 1'b0, 1'b1, 32'h0, 32'hAAAA0001, 1'b0, 32'h0, "b_st0", t);
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'hBBBB0002, 1'b0, 32'h0, "b_st4", t);
    access(1'b1, 1'b0, 1'b1, 32'h8, 32'hCCCC0003, 1'b0, 32'h0, "b_st8", t);
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hAAAA0001, "b_ld0", t1);
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'hBBBB0002, "b_ld4", t2);
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCCCC0003, "b_ld8", t3);
    chk("b spacing 1-2", t2 - t1, 32'd3);
    chk("b spacing 2-3", t3 - t2, 32'd3);
    access(1'b1, 1'b1, 1'b0, 32'h6, 32'h0, 1'b1, 32'hCCCC0003, "b_ill_mis", t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
